// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain
//   Drains a show-ahead FIFO into a valid/ready stream in framed bursts. A burst
//   is committed once the FIFO holds a full target burst, or once a partial
//   FIFO has sat idle for flushTimeout cycles. The committed length is frozen
//   until the burst completes. Output beats are registered and carry first-beat
//   (txSop) and last-beat (txEop) markers.
//
// Ports
//   clockCore, resetCore : clock, asynchronous active-low reset
//   fifoEmpty/fifoDepth  : FIFO status (occupancy 0..8)
//   fifoData/fifoPop     : FIFO head word and pop strobe
//   burstLen             : target burst length, 0 means 8
//   flushTimeout         : idle cycles before a short burst is forced, 0 = never
//   txData/txValid/txSop/txEop/txReady : registered output stream
//   busy                 : a burst is in progress
//   underrunErr          : sticky, FIFO ran dry inside a committed burst
module fifo_burst_drain #(
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned DEPTH_WIDTH = 4
) (
   input  logic                   clockCore,
   input  logic                   resetCore,
   input  logic                   fifoEmpty,
   input  logic [DEPTH_WIDTH-1:0] fifoDepth,
   input  logic [DATA_WIDTH-1:0]  fifoData,
   output logic                   fifoPop,
   input  logic [DEPTH_WIDTH-1:0] burstLen,
   input  logic [7:0]             flushTimeout,
   output logic [DATA_WIDTH-1:0]  txData,
   output logic                   txValid,
   output logic                   txSop,
   output logic                   txEop,
   input  logic                   txReady,
   output logic                   busy,
   output logic                   underrunErr
);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   localparam logic [DEPTH_WIDTH-1:0] MaxLen = DEPTH_WIDTH'(8);

   state_e                 state_q, state_d;
   logic [DEPTH_WIDTH-1:0] remaining_q, remaining_d;
   logic                   first_q, first_d;
   logic [7:0]             timer_q, timer_d;
   logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
   logic                   tx_valid_q, tx_valid_d;
   logic                   tx_sop_q, tx_sop_d;
   logic                   tx_eop_q, tx_eop_d;
   logic                   underrun_q, underrun_d;

   logic [DEPTH_WIDTH-1:0] eff_len;
   logic                   depth_ok;
   logic                   flush_ok;
   logic                   tx_accept;
   logic                   fifo_pop;

   assign eff_len   = (burstLen == '0) ? MaxLen : burstLen;
   assign depth_ok  = (fifoDepth >= eff_len);
   assign flush_ok  = (flushTimeout != 8'd0) && !fifoEmpty && (timer_q == flushTimeout);
   assign tx_accept = tx_valid_q && txReady;

   // Pop only when the output register is free or is being emptied this cycle.
   assign fifo_pop  = (state_q == StSend) && !fifoEmpty && (remaining_q != '0) &&
                      (!tx_valid_q || txReady);

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      first_d     = first_q;
      timer_d     = timer_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      tx_sop_d    = tx_sop_q;
      tx_eop_d    = tx_eop_q;
      underrun_d  = underrun_q;

      case (state_q)
         StIdle: begin
            if (fifoEmpty || depth_ok) begin
               timer_d = '0;
            end else if (timer_q != 8'hFF) begin
               timer_d = timer_q + 8'd1;
            end
            // A full burst wins over a timeout flush; length is latched here.
            if (depth_ok || flush_ok) begin
               state_d     = StSend;
               remaining_d = depth_ok ? eff_len : fifoDepth;
               first_d     = 1'b1;
               timer_d     = '0;
            end
         end
         StSend: begin
            timer_d = '0;
            if (fifoEmpty && (remaining_q != '0)) begin
               underrun_d = 1'b1;
            end
            // Leave once every beat is popped and the last one is gone or leaving.
            if ((remaining_q == '0) && (!tx_valid_q || txReady)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (fifo_pop) begin
         tx_data_d   = fifoData;
         tx_valid_d  = 1'b1;
         tx_sop_d    = first_q;
         tx_eop_d    = (remaining_q == DEPTH_WIDTH'(1));
         remaining_d = remaining_q - DEPTH_WIDTH'(1);
         first_d     = 1'b0;
      end else if (tx_accept) begin
         tx_valid_d = 1'b0;
         tx_sop_d   = 1'b0;
         tx_eop_d   = 1'b0;
      end
   end

   always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         first_q     <= 1'b0;
         timer_q     <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         tx_sop_q    <= 1'b0;
         tx_eop_q    <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         first_q     <= first_d;
         timer_q     <= timer_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         tx_sop_q    <= tx_sop_d;
         tx_eop_q    <= tx_eop_d;
         underrun_q  <= underrun_d;
      end
   end

   assign fifoPop     = fifo_pop;
   assign txData      = tx_data_q;
   assign txValid     = tx_valid_q;
   assign txSop       = tx_sop_q;
   assign txEop       = tx_eop_q;
   assign busy        = (state_q == StSend);
   assign underrunErr = underrun_q;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb_fifo_burst_drain
//   Bench for fifo_burst_drain. A queue acts as the show-ahead FIFO; expected
//   beat streams are built from the burst-framing rules (full bursts of effLen,
//   optional short flush of the remainder) and compared beat by beat.
module tb_fifo_burst_drain;

   localparam int DW = 64;
   localparam int AW = 4;

   typedef logic [DW+1:0] beat_t; // {sop, eop, data}

   logic          clockCore = 1'b0;
   logic          resetCore = 1'b0;
   logic          fifoEmpty;
   logic [AW-1:0] fifoDepth;
   logic [DW-1:0] fifoData;
   logic          fifoPop;
   logic [AW-1:0] burstLen = 4'd4;
   logic [7:0]    flushTimeout = 8'd0;
   logic [DW-1:0] txData;
   logic          txValid, txSop, txEop;
   logic          txReady = 1'b1;
   logic          busy, underrunErr;

   fifo_burst_drain #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) dut (
      .clockCore   (clockCore),
      .resetCore   (resetCore),
      .fifoEmpty   (fifoEmpty),
      .fifoDepth   (fifoDepth),
      .fifoData    (fifoData),
      .fifoPop     (fifoPop),
      .burstLen    (burstLen),
      .flushTimeout(flushTimeout),
      .txData      (txData),
      .txValid     (txValid),
      .txSop       (txSop),
      .txEop       (txEop),
      .txReady     (txReady),
      .busy        (busy),
      .underrunErr (underrunErr)
   );

   always #5 clockCore = ~clockCore;

   logic [DW-1:0] fq[$];  // FIFO contents
   logic [DW-1:0] wl[$];  // words not yet assigned to an expected burst
   beat_t         obs[$];
   beat_t         exp[$];
   int            acc_tick[$];
   logic          hist_busy[$];
   logic          hist_pop[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            ready_mode = 0;
   int            pat_idx = 0;
   int            cyc = 0;
   int            pop_cnt = 0;
   int            pop_stall_viol = 0;
   int            hold_viol = 0;
   int            pop_empty_viol = 0;
   bit            stall_prev = 1'b0;
   beat_t         held;
   logic          s_busy = 1'b0;
   logic          s_pop;

   task automatic drive_fifo();
      fifoEmpty = (fq.size() == 0);
      fifoDepth = AW'(fq.size());
      fifoData  = (fq.size() != 0) ? fq[0] : '0;
   endtask

   task automatic load(input int n);
      logic [DW-1:0] w;
      for (int i = 0; i < n; i++) begin
         w = {$urandom(), $urandom()};
         fq.push_back(w);
         wl.push_back(w);
      end
      drive_fifo();
   endtask

   // One clock: sample at negedge, apply the FIFO pop and new txReady after posedge.
   task automatic tick();
      @(negedge clockCore);
      s_pop  = fifoPop;
      s_busy = busy;
      hist_busy.push_back(busy);
      hist_pop.push_back(fifoPop);
      if (fifoPop && txValid && !txReady) pop_stall_viol++;
      if (fifoPop && fifoEmpty) pop_empty_viol++;
      if (stall_prev && (!txValid || ({txSop, txEop, txData} !== held))) hold_viol++;
      stall_prev = txValid && !txReady;
      held = {txSop, txEop, txData};
      if (txValid && txReady) begin
         obs.push_back({txSop, txEop, txData});
         acc_tick.push_back(cyc);
      end
      if (fifoPop) pop_cnt++;
      @(posedge clockCore);
      #1;
      if (s_pop && fq.size() > 0) void'(fq.pop_front());
      cyc++;
      case (ready_mode)
         0: txReady = 1'b1;
         1: txReady = ($urandom_range(0, 9) < 7);
         default: begin
            pat_idx++;
            txReady = (pat_idx % 3 == 0);
         end
      endcase
      drive_fifo();
   endtask

   task automatic clear_obs();
      obs.delete(); exp.delete(); wl.delete(); acc_tick.delete();
      hist_busy.delete(); hist_pop.delete();
      cyc = 0; pop_cnt = 0; pop_stall_viol = 0; hold_viol = 0; pop_empty_viol = 0;
      stall_prev = 1'b0; s_busy = 1'b0;
   endtask

   function automatic void add_burst(input int len);
      logic [DW-1:0] w;
      for (int k = 0; k < len; k++) begin
         w = wl.pop_front();
         exp.push_back({(k == 0), (k == len - 1), w});
      end
   endfunction

   // Framing of n static words: full bursts of eff, then a flush of the rest
   // only when a timeout is enabled.
   function automatic void model(input int eff, input int t, input int n);
      int rem = n;
      while (rem >= eff) begin
         add_burst(eff);
         rem -= eff;
      end
      if (rem > 0 && t != 0) add_burst(rem);
   endfunction

   task automatic run_until(input int nbeats, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (obs.size() >= nbeats && !s_busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(posedge clockCore);
      #1;
      clear_obs();
      burstLen = 4'd4;
      load(5);
      #1;
      n_checks += 7;
      if (txValid !== 1'b0) begin n_fail++; $display("FAIL reset txValid: got %b want 0", txValid); end
      if (txSop !== 1'b0) begin n_fail++; $display("FAIL reset txSop: got %b want 0", txSop); end
      if (txEop !== 1'b0) begin n_fail++; $display("FAIL reset txEop: got %b want 0", txEop); end
      if (txData !== '0) begin n_fail++; $display("FAIL reset txData: got %h want 0", txData); end
      if (fifoPop !== 1'b0) begin n_fail++; $display("FAIL reset fifoPop: got %b want 0", fifoPop); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
      if (underrunErr !== 1'b0) begin n_fail++; $display("FAIL reset underrunErr: got %b want 0", underrunErr); end
      repeat (3) @(posedge clockCore);
      #1;
      n_checks += 2;
      if (fifoPop !== 1'b0) begin n_fail++; $display("FAIL reset held fifoPop: got %b want 0", fifoPop); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset held busy: got %b want 0", busy); end
      fq.delete();
      drive_fifo();
   endtask

   // 4 preloaded words, release reset, check cycle-exact latencies.
   task automatic test_basic_burst();
      logic want_pop;
      clear_obs();
      ready_mode = 0; txReady = 1'b1; burstLen = 4'd4; flushTimeout = 8'd0;
      load(4);
      model(4, 0, 4);
      resetCore = 1'b1;
      repeat (10) tick();
      for (int i = 0; i < 8; i++) begin
         want_pop = (i >= 1 && i <= 4);
         n_checks++;
         if (hist_pop[i] !== want_pop) begin
            n_fail++; $display("FAIL basic fifoPop cycle %0d: got %b want %b", i, hist_pop[i], want_pop);
         end
      end
      n_checks++;
      if (acc_tick.size() != 4) begin
         n_fail++; $display("FAIL basic accept count: got %0d want 4", acc_tick.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (acc_tick[k] != 2 + k) begin
               n_fail++; $display("FAIL basic accept cycle %0d: got %0d want %0d", k, acc_tick[k], 2 + k);
            end
         end
      end
      n_checks += 3;
      if (hist_busy[0] !== 1'b0) begin n_fail++; $display("FAIL basic busy before commit: got %b want 0", hist_busy[0]); end
      if (hist_busy[5] !== 1'b1) begin n_fail++; $display("FAIL basic busy during last beat: got %b want 1", hist_busy[5]); end
      if (hist_busy[6] !== 1'b0) begin n_fail++; $display("FAIL basic busy after last beat: got %b want 0", hist_busy[6]); end
      n_checks++;
      if (obs.size() != exp.size()) begin n_fail++; $display("FAIL basic beat count: got %0d want %0d", obs.size(), exp.size()); end
      for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
         n_checks++;
         if (obs[i] !== exp[i]) begin n_fail++; $display("FAIL basic beat %0d {sop,eop,data}: got %h want %h", i, obs[i], exp[i]); end
      end
   endtask

   task automatic test_len8();
      bit ok;
      clear_obs();
      ready_mode = 0; burstLen = 4'd0; flushTimeout = 8'd0;
      load(8);
      model(8, 0, 8);
      run_until(8, 60, ok);
      n_checks += 4;
      if (!ok) begin n_fail++; $display("FAIL len8 completion: got beats=%0d want 8 and idle", obs.size()); end
      if (fifoDepth !== 4'd0) begin n_fail++; $display("FAIL len8 fifoDepth: got %0d want 0", fifoDepth); end
      if (pop_cnt != 8) begin n_fail++; $display("FAIL len8 pops: got %0d want 8", pop_cnt); end
      if (acc_tick.size() == 8 && acc_tick[7] - acc_tick[0] != 7) begin
         n_fail++; $display("FAIL len8 throughput span: got %0d want 7", acc_tick[7] - acc_tick[0]);
      end
      n_checks++;
      if (obs.size() != exp.size()) begin n_fail++; $display("FAIL len8 beat count: got %0d want %0d", obs.size(), exp.size()); end
      for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
         n_checks++;
         if (obs[i] !== exp[i]) begin n_fail++; $display("FAIL len8 beat %0d {sop,eop,data}: got %h want %h", i, obs[i], exp[i]); end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int first_busy;
      clear_obs();
      ready_mode = 0; burstLen = 4'd8; flushTimeout = 8'd10;
      load(3);
      model(8, 10, 3);
      run_until(3, 80, ok);
      first_busy = -1;
      for (int i = 0; i < hist_busy.size(); i++) begin
         if (hist_busy[i] === 1'b1 && first_busy < 0) first_busy = i;
      end
      // Timer reaches 10 after 10 edges, commit on the 11th, seen busy one sample later.
      n_checks += 2;
      if (!ok) begin n_fail++; $display("FAIL timeout completion: got beats=%0d want 3", obs.size()); end
      if (first_busy != 11) begin n_fail++; $display("FAIL timeout commit cycle: got %0d want 11", first_busy); end
      n_checks++;
      if (obs.size() != exp.size()) begin n_fail++; $display("FAIL timeout beat count: got %0d want %0d", obs.size(), exp.size()); end
      for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
         n_checks++;
         if (obs[i] !== exp[i]) begin n_fail++; $display("FAIL timeout beat %0d {sop,eop,data}: got %h want %h", i, obs[i], exp[i]); end
      end
      flushTimeout = 8'd0;
   endtask

   task automatic test_stall();
      bit ok;
      clear_obs();
      ready_mode = 2; pat_idx = 0; txReady = 1'b1; burstLen = 4'd4; flushTimeout = 8'd0;
      load(4);
      model(4, 0, 4);
      run_until(4, 80, ok);
      n_checks += 3;
      if (!ok) begin n_fail++; $display("FAIL stall completion: got beats=%0d want 4", obs.size()); end
      if (pop_stall_viol != 0) begin n_fail++; $display("FAIL stall pop while stalled: got %0d want 0", pop_stall_viol); end
      if (hold_viol != 0) begin n_fail++; $display("FAIL stall output hold: got %0d changes want 0", hold_viol); end
      n_checks++;
      if (obs.size() != exp.size()) begin n_fail++; $display("FAIL stall beat count: got %0d want %0d", obs.size(), exp.size()); end
      for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
         n_checks++;
         if (obs[i] !== exp[i]) begin n_fail++; $display("FAIL stall beat %0d {sop,eop,data}: got %h want %h", i, obs[i], exp[i]); end
      end
      ready_mode = 0; txReady = 1'b1;
   endtask

   task automatic test_len1();
      bit ok;
      int busy_cnt;
      clear_obs();
      ready_mode = 0; burstLen = 4'd1; flushTimeout = 8'd0;
      load(2);
      model(1, 0, 2);
      run_until(2, 40, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL len1 completion: got beats=%0d want 2", obs.size()); end
      n_checks++;
      if (obs.size() != exp.size()) begin n_fail++; $display("FAIL len1 beat count: got %0d want %0d", obs.size(), exp.size()); end
      for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
         n_checks++;
         if (obs[i] !== exp[i]) begin n_fail++; $display("FAIL len1 beat %0d {sop,eop,data}: got %h want %h", i, obs[i], exp[i]); end
      end
      clear_obs();
      repeat (40) tick();
      busy_cnt = 0;
      foreach (hist_busy[i]) if (hist_busy[i] !== 1'b0) busy_cnt++;
      n_checks += 2;
      if (busy_cnt != 0) begin n_fail++; $display("FAIL len1 empty busy cycles: got %0d want 0", busy_cnt); end
      if (pop_cnt != 0) begin n_fail++; $display("FAIL len1 empty pops: got %0d want 0", pop_cnt); end
   endtask

   // Pushes and burstLen changes after commit must not alter the committed burst.
   task automatic test_push_during_send();
      bit ok;
      clear_obs();
      ready_mode = 0; burstLen = 4'd4; flushTimeout = 8'd0;
      load(4);
      for (int i = 0; i < 10 && !s_busy; i++) tick();
      burstLen = 4'd1;
      load(3);
      model(4, 0, 4);
      model(1, 0, 3);
      run_until(7, 80, ok);
      n_checks += 2;
      if (!ok) begin n_fail++; $display("FAIL push completion: got beats=%0d want 7", obs.size()); end
      if (fifoDepth !== 4'd0) begin n_fail++; $display("FAIL push fifoDepth: got %0d want 0", fifoDepth); end
      n_checks++;
      if (obs.size() != exp.size()) begin n_fail++; $display("FAIL push beat count: got %0d want %0d", obs.size(), exp.size()); end
      for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
         n_checks++;
         if (obs[i] !== exp[i]) begin n_fail++; $display("FAIL push beat %0d {sop,eop,data}: got %h want %h", i, obs[i], exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear_obs();
      ready_mode = 0; burstLen = 4'd4; flushTimeout = 8'd0;
      load(4);
      for (int i = 0; i < 20 && obs.size() < 2; i++) tick();
      n_checks++;
      if (obs.size() != 2) begin n_fail++; $display("FAIL resetmid beats before reset: got %0d want 2", obs.size()); end
      resetCore = 1'b0;
      #1;
      n_checks += 6;
      if (txValid !== 1'b0) begin n_fail++; $display("FAIL resetmid txValid: got %b want 0", txValid); end
      if (txSop !== 1'b0) begin n_fail++; $display("FAIL resetmid txSop: got %b want 0", txSop); end
      if (txEop !== 1'b0) begin n_fail++; $display("FAIL resetmid txEop: got %b want 0", txEop); end
      if (txData !== '0) begin n_fail++; $display("FAIL resetmid txData: got %h want 0", txData); end
      if (fifoPop !== 1'b0) begin n_fail++; $display("FAIL resetmid fifoPop: got %b want 0", fifoPop); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL resetmid busy: got %b want 0", busy); end
      load(4 - fq.size());
      repeat (2) @(posedge clockCore);
      #1;
      clear_obs();
      wl = fq;
      model(4, 0, 4);
      resetCore = 1'b1;
      run_until(4, 40, ok);
      n_checks += 2;
      if (!ok) begin n_fail++; $display("FAIL resetmid completion: got beats=%0d want 4", obs.size()); end
      if (underrunErr !== 1'b0) begin n_fail++; $display("FAIL resetmid underrunErr: got %b want 0", underrunErr); end
      n_checks++;
      if (obs.size() != exp.size()) begin n_fail++; $display("FAIL resetmid beat count: got %0d want %0d", obs.size(), exp.size()); end
      for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
         n_checks++;
         if (obs[i] !== exp[i]) begin n_fail++; $display("FAIL resetmid beat %0d {sop,eop,data}: got %h want %h", i, obs[i], exp[i]); end
      end
   endtask

   // FIFO words vanish under the committed burst; the block must wait, flag it, resume.
   task automatic test_underrun();
      bit ok;
      logic [DW-1:0] w0, w1;
      clear_obs();
      ready_mode = 0; burstLen = 4'd4; flushTimeout = 8'd0;
      load(4);
      w0 = wl[0];
      w1 = wl[1];
      for (int i = 0; i < 10 && !s_busy; i++) tick();
      while (fq.size() > 1) void'(fq.pop_back());
      drive_fifo();
      wl.delete();
      wl.push_back(w0);
      wl.push_back(w1);
      repeat (6) tick();
      n_checks += 4;
      if (underrunErr !== 1'b1) begin n_fail++; $display("FAIL underrun flag: got %b want 1", underrunErr); end
      if (s_busy !== 1'b1) begin n_fail++; $display("FAIL underrun busy: got %b want 1", s_busy); end
      if (pop_empty_viol != 0) begin n_fail++; $display("FAIL underrun pop while empty: got %0d want 0", pop_empty_viol); end
      if (obs.size() != 2) begin n_fail++; $display("FAIL underrun beats so far: got %0d want 2", obs.size()); end
      load(2);
      model(4, 0, 4);
      run_until(4, 40, ok);
      n_checks += 2;
      if (!ok) begin n_fail++; $display("FAIL underrun completion: got beats=%0d want 4", obs.size()); end
      if (underrunErr !== 1'b1) begin n_fail++; $display("FAIL underrun sticky: got %b want 1", underrunErr); end
      n_checks++;
      if (obs.size() != exp.size()) begin n_fail++; $display("FAIL underrun beat count: got %0d want %0d", obs.size(), exp.size()); end
      for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
         n_checks++;
         if (obs[i] !== exp[i]) begin n_fail++; $display("FAIL underrun beat %0d {sop,eop,data}: got %h want %h", i, obs[i], exp[i]); end
      end
      resetCore = 1'b0;
      #1;
      n_checks++;
      if (underrunErr !== 1'b0) begin n_fail++; $display("FAIL underrun cleared by reset: got %b want 0", underrunErr); end
      repeat (2) @(posedge clockCore);
      #1;
      resetCore = 1'b1;
   endtask

   task automatic test_random();
      bit ok;
      int n, bl, t, eff;
      int stall_sum = 0;
      int hold_sum = 0;
      for (int it = 0; it < 40; it++) begin
         clear_obs();
         n  = $urandom_range(1, 8);
         bl = $urandom_range(0, 8);
         t  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
         ready_mode = $urandom_range(0, 1);
         burstLen = AW'(bl);
         flushTimeout = 8'(t);
         eff = (bl == 0) ? 8 : bl;
         load(n);
         model(eff, t, n);
         run_until(exp.size(), 300, ok);
         repeat (30) tick();
         stall_sum += pop_stall_viol;
         hold_sum += hold_viol;
         n_checks += 3;
         if (!ok) begin n_fail++; $display("FAIL random it%0d completion: got beats=%0d want %0d", it, obs.size(), exp.size()); end
         if (fq.size() != wl.size()) begin n_fail++; $display("FAIL random it%0d leftover words: got %0d want %0d", it, fq.size(), wl.size()); end
         if (busy !== 1'b0) begin n_fail++; $display("FAIL random it%0d busy at end: got %b want 0", it, busy); end
         n_checks++;
         if (obs.size() != exp.size()) begin n_fail++; $display("FAIL random it%0d beat count: got %0d want %0d", it, obs.size(), exp.size()); end
         for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp[i]) begin n_fail++; $display("FAIL random it%0d beat %0d {sop,eop,data}: got %h want %h", it, i, obs[i], exp[i]); end
         end
         fq.delete();
         drive_fifo();
         repeat (2) tick();
      end
      n_checks += 2;
      if (stall_sum != 0) begin n_fail++; $display("FAIL random pop while stalled: got %0d want 0", stall_sum); end
      if (hold_sum != 0) begin n_fail++; $display("FAIL random output hold: got %0d changes want 0", hold_sum); end
   endtask

   initial begin
      drive_fifo();
      test_reset();
      test_basic_burst();
      test_len8();
      test_timeout();
      test_stall();
      test_len1();
      test_push_during_send();
      test_reset_mid();
      test_underrun();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fifo_burst_drain.md
FIFO_BURST_DRAIN -- requirements
Module: fifo_burst_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the FIFO word and stream data width.
REQ-002 Parameter DEPTH_WIDTH, default 4, SHALL set the width of fifoDepth, burstLen and the remaining-beat counter.
REQ-003 clockCore  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 resetCore  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 fifoEmpty  input  1  SHALL be the FIFO empty flag.
REQ-006 fifoDepth  input  DEPTH_WIDTH  SHALL be the FIFO occupancy, 0..8.
REQ-007 fifoData  input  DATA_WIDTH  SHALL be the FIFO head word (show-ahead), valid when fifoEmpty=0.
REQ-008 fifoPop  output  1  SHALL be the FIFO pop strobe; the head word is consumed on each cycle it is 1.
REQ-009 burstLen  input  DEPTH_WIDTH  SHALL be the target burst length in beats: 1..8, with 0 meaning 8.
REQ-010 flushTimeout  input  8  SHALL be the number of idle cycles before a short burst is forced; 0 disables the timeout.
REQ-011 txData  output  DATA_WIDTH  SHALL be the registered stream data.
REQ-012 txValid / txSop / txEop  output  1 each  SHALL be the registered beat-valid, first-beat and last-beat flags.
REQ-013 txReady  input  1  SHALL be the downstream accept; a beat transfers when txValid=1 and txReady=1.
REQ-014 busy  output  1  SHALL be 1 whenever the state is not IDLE.
REQ-015 underrunErr  output  1  SHALL be a sticky flag set when a committed burst finds fifoEmpty=1.

Function
REQ-016 The FSM SHALL have two states: IDLE and SEND.
REQ-017 effLen SHALL equal burstLen, except that burstLen=0 gives effLen=8.
REQ-018 IDLE timer (8 bits):
  - clears when fifoEmpty=1 or fifoDepth>=effLen;
  - otherwise increments, saturating at 255.
REQ-019 IDLE -> SEND SHALL occur on the first cycle either condition holds:
  - fifoDepth>=effLen: commit len=effLen;
  - flushTimeout!=0, fifoEmpty=0 and timer==flushTimeout: commit len=fifoDepth (short burst).
REQ-020 On commit the block SHALL:
  - load remaining=len and set first=1;
  - clear the timer;
  - ignore later burstLen changes until the next commit.
REQ-021 In SEND, fifoPop SHALL be fifoEmpty=0 AND remaining!=0 AND (txValid=0 OR txReady=1); fifoPop SHALL be 0 in IDLE.
REQ-022 On a pop cycle the next-edge updates SHALL be:
  - txData<=fifoData, txValid<=1;
  - txSop<=first, txEop<=(remaining==1);
  - remaining decrements, first<=0.
REQ-023 On a non-pop cycle with txValid=1 and txReady=1, txValid, txSop and txEop SHALL clear.
REQ-024 While txValid=1 and txReady=0, txData, txSop and txEop SHALL hold stable.
REQ-025 Pop-to-txValid latency SHALL be 1 cycle, and commit-to-first-pop latency SHALL be 1 cycle.
REQ-026 Sustained throughput SHALL be 1 beat per cycle while txReady=1 and the FIFO is non-empty.
REQ-027 SEND -> IDLE SHALL occur when remaining==0 and the txEop beat is accepted (or txValid is already 0).
REQ-028 The next burst SHALL be able to commit no earlier than the cycle after the return to IDLE.
REQ-029 In SEND with remaining!=0 and fifoEmpty=1, the block SHALL:
  - set underrunErr, held until reset;
  - suppress fifoPop;
  - stay in SEND and resume when data arrives.
REQ-030 Each burst SHALL have exactly one txSop beat and one txEop beat; for len=1 the single beat SHALL carry txSop=txEop=1.
REQ-031 Push-side activity SHALL NOT affect a committed len; fifoDepth growth during SEND SHALL be ignored.

Reset
REQ-032 When resetCore=0, all of the following SHALL be forced immediately (asynchronously):
  - state=IDLE;
  - fifoPop=0;
  - txValid=txSop=txEop=0 and txData=0;
  - remaining=0, first=0, timer=0;
  - busy=0, underrunErr=0.
REQ-033 Reset asserted mid-burst SHALL discard the burst; words already popped are lost and no txEop is issued.
REQ-034 After reset release, the first commit SHALL be evaluated on the first rising edge with resetCore=1.

Verification
REQ-035 burstLen=4, FIFO preloaded with 4 words A..D, txReady=1 -> 4 consecutive beats A..D, txSop on A, txEop on D, fifoPop high for 4 cycles, busy falls after the D beat.
REQ-036 burstLen=0 and 8 words -> one 8-beat burst; txEop on the 8th beat; fifoDepth reaches 0.
REQ-037 burstLen=8, 3 words, flushTimeout=10 -> commit exactly 10 cycles after the timer starts; 3-beat burst with txSop on beat 1 and txEop on beat 3.
REQ-038 4-beat burst with txReady toggling 1,0,0,1,... -> no beat lost or duplicated; txData stable while stalled; fifoPop never 1 while txValid=1 and txReady=0.
REQ-039 burstLen=1, flushTimeout=0, 2 words -> two 1-beat bursts, each with txSop=txEop=1; with 0 words and flushTimeout=0 -> busy stays 0 indefinitely.
REQ-040 resetCore pulled low after beat 2 of a 4-beat burst -> all outputs 0 within the reset; after release a fresh burst starts with txSop=1; underrunErr=0.
